// File: rtl/lbm_pkg.sv
// Shared lattice geometry and sweep FSM state encoding for the D2Q9 sweep controller.
package lbm_pkg;

    localparam int DEPTH         = 16 * 16;
    localparam int ADDRESS_WIDTH = $clog2(DEPTH);
    localparam int Q             = 9;
    localparam int POP_WIDTH     = 32;
    localparam int DATA_WIDTH    = Q * POP_WIDTH;
    localparam int STEP_WIDTH    = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_PRESENT,
        ST_DRAIN,
        ST_NEXT,
        ST_DONE
    } sweep_state_t;

endpackage

// File: rtl/lbm_bank_mux.sv
// Steers the read port to the source bank and the result write to the destination bank.
// src_sel=0 reads A and writes B; src_sel=1 reads B and writes A. Idle ports park at zero.
module lbm_bank_mux #(
    parameter int ADDRESS_WIDTH = lbm_pkg::ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = lbm_pkg::DATA_WIDTH
) (
    input  logic                     src_sel,
    input  logic                     rd_en,
    input  logic [ADDRESS_WIDTH-1:0] rd_address,
    output logic [DATA_WIDTH-1:0]    rd_data,
    input  logic                     wr_en,
    input  logic [ADDRESS_WIDTH-1:0] wr_address,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    output logic [ADDRESS_WIDTH-1:0] a_address,
    output logic                     a_WE,
    output logic [DATA_WIDTH-1:0]    a_data_in,
    input  logic [DATA_WIDTH-1:0]    a_data_out,
    output logic [ADDRESS_WIDTH-1:0] b_address,
    output logic                     b_WE,
    output logic [DATA_WIDTH-1:0]    b_data_in,
    input  logic [DATA_WIDTH-1:0]    b_data_out
);

    // Route read/write traffic to the bank each one targets this step.
    always_comb begin
        a_address = '0;
        a_WE      = 1'b0;
        a_data_in = '0;
        b_address = '0;
        b_WE      = 1'b0;
        b_data_in = '0;
        rd_data   = src_sel ? b_data_out : a_data_out;
        if (!src_sel) begin
            a_address = rd_en ? rd_address : '0;
            b_address = wr_en ? wr_address : '0;
            b_WE      = wr_en;
            b_data_in = wr_en ? wr_data : '0;
        end else begin
            b_address = rd_en ? rd_address : '0;
            a_address = wr_en ? wr_address : '0;
            a_WE      = wr_en;
            a_data_in = wr_en ? wr_data : '0;
        end
    end

endmodule

// File: rtl/lbm_sweep_ctrl.sv
// D2Q9 time-step sequencer: sweeps every cell of the source bank into the PE,
// writes PE results into the destination bank, and swaps banks between steps.
module lbm_sweep_ctrl
    import lbm_pkg::*;
#(
    parameter int DEPTH         = lbm_pkg::DEPTH,
    parameter int ADDRESS_WIDTH = $clog2(DEPTH),
    parameter int DATA_WIDTH    = lbm_pkg::DATA_WIDTH,
    parameter int STEP_WIDTH    = lbm_pkg::STEP_WIDTH
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     start,
    input  logic [STEP_WIDTH-1:0]    num_steps,
    output logic                     busy,
    output logic                     done,
    output logic [STEP_WIDTH-1:0]    step_count,
    output logic                     result_bank,
    output logic [ADDRESS_WIDTH-1:0] a_address,
    output logic                     a_WE,
    output logic [DATA_WIDTH-1:0]    a_data_in,
    input  logic [DATA_WIDTH-1:0]    a_data_out,
    output logic [ADDRESS_WIDTH-1:0] b_address,
    output logic                     b_WE,
    output logic [DATA_WIDTH-1:0]    b_data_in,
    input  logic [DATA_WIDTH-1:0]    b_data_out,
    output logic                     pe_in_valid,
    input  logic                     pe_in_ready,
    output logic [DATA_WIDTH-1:0]    pe_in_data,
    output logic [ADDRESS_WIDTH-1:0] pe_in_address,
    input  logic                     pe_out_valid,
    output logic                     pe_out_ready,
    input  logic [DATA_WIDTH-1:0]    pe_out_data,
    input  logic [ADDRESS_WIDTH-1:0] pe_out_address
);

    localparam logic [ADDRESS_WIDTH-1:0] LAST_CELL = ADDRESS_WIDTH'(DEPTH - 1);
    localparam logic [STEP_WIDTH-1:0]    STEP_ONE  = STEP_WIDTH'(1);
    localparam logic [ADDRESS_WIDTH:0]   OUT_ONE   = (ADDRESS_WIDTH + 1)'(1);

    sweep_state_t                 state_q, state_d;
    logic [ADDRESS_WIDTH-1:0]     cell_q, cell_d;
    logic [STEP_WIDTH-1:0]        step_count_q, step_count_d;
    logic [STEP_WIDTH-1:0]        num_steps_q, num_steps_d;
    logic                         result_bank_q, result_bank_d;
    logic [ADDRESS_WIDTH:0]       outstanding_q, outstanding_d;
    logic [DATA_WIDTH-1:0]        pe_data_q, pe_data_d;

    logic                         active;
    logic                         issue;
    logic                         retire_ok;
    logic                         retire;
    logic                         rd_en;
    logic                         wr_en;
    logic [DATA_WIDTH-1:0]        rd_data;

    // Even steps read A and write B; odd steps the reverse.
    lbm_bank_mux #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH)
    ) u_bank_mux (
        .src_sel    (step_count_q[0]),
        .rd_en      (rd_en),
        .rd_address (cell_q),
        .rd_data    (rd_data),
        .wr_en      (wr_en),
        .wr_address (pe_out_address),
        .wr_data    (pe_out_data),
        .a_address  (a_address),
        .a_WE       (a_WE),
        .a_data_in  (a_data_in),
        .a_data_out (a_data_out),
        .b_address  (b_address),
        .b_WE       (b_WE),
        .b_data_in  (b_data_in),
        .b_data_out (b_data_out)
    );

    // Next-state, counters and handshakes for the sweep.
    always_comb begin
        state_d       = state_q;
        cell_d        = cell_q;
        step_count_d  = step_count_q;
        num_steps_d   = num_steps_q;
        result_bank_d = result_bank_q;
        outstanding_d = outstanding_q;
        pe_data_d     = pe_data_q;
        rd_en         = 1'b0;
        pe_in_valid   = 1'b0;

        active = (state_q == ST_READ) || (state_q == ST_WAIT) ||
                 (state_q == ST_PRESENT) || (state_q == ST_DRAIN);
        pe_out_ready = active;
        issue        = (state_q == ST_PRESENT) && pe_in_ready;
        // A zero-latency PE may retire the vector being issued this very cycle.
        retire_ok    = (outstanding_q != '0) || issue;
        retire       = active && pe_out_valid && retire_ok;
        // Reset kills the write in the same cycle so an aborted step never lands one more word.
        wr_en        = retire && !Reset;

        case ({issue, retire})
            2'b10:   outstanding_d = outstanding_q + OUT_ONE;
            2'b01:   outstanding_d = outstanding_q - OUT_ONE;
            default: outstanding_d = outstanding_q;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    num_steps_d  = num_steps;
                    step_count_d = '0;
                    cell_d       = '0;
                    state_d      = (num_steps == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                rd_en   = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                rd_en     = 1'b1;
                pe_data_d = rd_data;
                state_d   = ST_PRESENT;
            end
            ST_PRESENT: begin
                rd_en       = 1'b1;
                pe_in_valid = 1'b1;
                if (pe_in_ready) begin
                    if (cell_q == LAST_CELL) begin
                        state_d = ST_DRAIN;
                    end else begin
                        cell_d  = cell_q + 1'b1;
                        state_d = ST_READ;
                    end
                end
            end
            ST_DRAIN: begin
                if (outstanding_q == '0) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                step_count_d  = step_count_q + STEP_ONE;
                result_bank_d = ~step_count_q[0];
                if ((step_count_q + STEP_ONE) == num_steps_q) begin
                    state_d = ST_DONE;
                end else begin
                    cell_d  = '0;
                    state_d = ST_READ;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state; reset aborts any run in progress.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= ST_IDLE;
            cell_q        <= '0;
            step_count_q  <= '0;
            num_steps_q   <= '0;
            result_bank_q <= 1'b0;
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            cell_q        <= cell_d;
            step_count_q  <= step_count_d;
            num_steps_q   <= num_steps_d;
            result_bank_q <= result_bank_d;
            outstanding_q <= outstanding_d;
        end
    end

    // Cell vector captured from the RAM so it stays put while the PE stalls.
    always_ff @(posedge Clk) begin
        pe_data_q <= pe_data_d;
    end

    assign busy          = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done          = (state_q == ST_DONE);
    assign step_count    = step_count_q;
    assign result_bank   = result_bank_q;
    assign pe_in_data    = pe_data_q;
    assign pe_in_address = cell_q;

    // A result with nothing in flight means the PE is misbehaving; the write is dropped.
    a_no_orphan_result: assert property (@(posedge Clk) disable iff (Reset)
        !(active && pe_out_valid && !retire_ok));

endmodule

// File: tb/tb_lbm_sweep_ctrl.sv
// Directed bench for lbm_sweep_ctrl with behavioural RAMs and a configurable PE model.
module tb_lbm_sweep_ctrl;

    localparam int DW = 288;
    localparam int AW = 8;
    localparam int SW = 16;
    localparam int N  = 256;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          start;
    logic [SW-1:0] num_steps;
    logic          busy, done, result_bank;
    logic [SW-1:0] step_count;
    logic [AW-1:0] a_address, b_address;
    logic          a_WE, b_WE;
    logic [DW-1:0] a_data_in, b_data_in, a_data_out, b_data_out;
    logic          pe_in_valid, pe_in_ready, pe_out_valid, pe_out_ready;
    logic [DW-1:0] pe_in_data, pe_out_data;
    logic [AW-1:0] pe_in_address, pe_out_address;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    lbm_sweep_ctrl dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .start          (start),
        .num_steps      (num_steps),
        .busy           (busy),
        .done           (done),
        .step_count     (step_count),
        .result_bank    (result_bank),
        .a_address      (a_address),
        .a_WE           (a_WE),
        .a_data_in      (a_data_in),
        .a_data_out     (a_data_out),
        .b_address      (b_address),
        .b_WE           (b_WE),
        .b_data_in      (b_data_in),
        .b_data_out     (b_data_out),
        .pe_in_valid    (pe_in_valid),
        .pe_in_ready    (pe_in_ready),
        .pe_in_data     (pe_in_data),
        .pe_in_address  (pe_in_address),
        .pe_out_valid   (pe_out_valid),
        .pe_out_ready   (pe_out_ready),
        .pe_out_data    (pe_out_data),
        .pe_out_address (pe_out_address)
    );

    // Cell i population p starts at i - 1000*p; k steps of the +1 PE add k to every population.
    function automatic logic [DW-1:0] exp_vec(input int i, input int k);
        logic [DW-1:0] r;
        for (int p = 0; p < 9; p++) r[p*32 +: 32] = 32'(i) - 32'(p * 1000) + 32'(k);
        return r;
    endfunction

    function automatic logic [DW-1:0] pe_fn(input logic [DW-1:0] v, input logic add);
        logic [DW-1:0] r;
        for (int p = 0; p < 9; p++) r[p*32 +: 32] = v[p*32 +: 32] + {31'd0, add};
        return r;
    endfunction

    // Behavioural RAMs: registered read, write-enable port, one-shot preload.
    logic [DW-1:0] mem_a [0:N-1];
    logic [DW-1:0] mem_b [0:N-1];
    logic          preload_en;

    always @(posedge Clk) begin
        if (preload_en) begin
            for (int i = 0; i < N; i++) begin
                mem_a[i] <= exp_vec(i, 0);
                mem_b[i] <= '0;
            end
        end else begin
            if (a_WE) mem_a[a_address] <= a_data_in;
            if (b_WE) mem_b[b_address] <= b_data_in;
        end
        a_data_out <= mem_a[a_address];
        b_data_out <= mem_b[b_address];
    end

    // PE model: zero-latency pass-through, or a 4-deep FIFO with random stalls.
    logic          pe_fifo_mode;
    logic          pe_add;
    logic [DW-1:0] fd [0:3];
    logic [AW-1:0] fa [0:3];
    logic [1:0]    wp, rp;
    logic [2:0]    cnt;
    logic          rdy_r, vld_r;
    logic          push, pop;

    assign pe_in_ready    = pe_fifo_mode ? ((cnt != 3'd4) && rdy_r) : 1'b1;
    assign pe_out_valid   = pe_fifo_mode ? ((cnt != 3'd0) && vld_r) : pe_in_valid;
    assign pe_out_data    = pe_fifo_mode ? fd[rp] : pe_fn(pe_in_data, pe_add);
    assign pe_out_address = pe_fifo_mode ? fa[rp] : pe_in_address;
    assign push           = pe_fifo_mode && pe_in_valid && pe_in_ready;
    assign pop            = pe_fifo_mode && pe_out_valid && pe_out_ready;

    always @(posedge Clk) begin
        rdy_r <= ($urandom_range(0, 3) != 0);
        vld_r <= ($urandom_range(0, 2) != 0);
        if (Reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) begin
                fd[wp] <= pe_fn(pe_in_data, pe_add);
                fa[wp] <= pe_in_address;
                wp     <= wp + 2'd1;
            end
            if (pop) rp <= rp + 2'd1;
            cnt <= cnt + {2'b0, push} - {2'b0, pop};
        end
    end

    // Event monitor: write enables, done pulses, PE-input stability while stalled.
    int            we_cnt = 0;
    int            done_cnt = 0;
    int            stall_seen = 0;
    int            stall_viol = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic [AW-1:0] prev_addr;

    always @(negedge Clk) begin
        if (a_WE || b_WE) we_cnt <= we_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (pe_in_valid && !pe_in_ready) stall_seen <= stall_seen + 1;
        if (prev_stall && !Reset &&
            (!pe_in_valid || pe_in_data !== prev_data || pe_in_address !== prev_addr))
            stall_viol <= stall_viol + 1;
        prev_stall <= pe_in_valid && !pe_in_ready && !Reset;
        prev_data  <= pe_in_data;
        prev_addr  <= pe_in_address;
    end

    task automatic preload();
        @(negedge Clk) preload_en = 1'b1;
        @(negedge Clk) preload_en = 1'b0;
    endtask

    task automatic start_run(input logic [SW-1:0] n);
        @(negedge Clk);
        start     = 1'b1;
        num_steps = n;
        @(negedge Clk);
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc, output bit to);
        cyc = 0;
        to  = 1'b0;
        while (done !== 1'b1) begin
            if (cyc >= budget) begin
                to = 1'b1;
                break;
            end
            @(negedge Clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", done); end
        checks++; if (step_count !== 16'd0) begin errors++; $display("FAIL rst_step got %0d exp 0", step_count); end
        checks++; if (result_bank !== 1'b0) begin errors++; $display("FAIL rst_bank got %b exp 0", result_bank); end
        checks++; if ({a_WE, b_WE} !== 2'b00) begin errors++; $display("FAIL rst_we got %b exp 00", {a_WE, b_WE}); end
        checks++; if ({pe_in_valid, pe_out_ready} !== 2'b00) begin errors++; $display("FAIL rst_pe got %b exp 00", {pe_in_valid, pe_out_ready}); end
        checks++; if ({a_address, b_address} !== 16'd0) begin errors++; $display("FAIL rst_addr got %h exp 0000", {a_address, b_address}); end
        Reset = 1'b0;
        @(negedge Clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle_busy got %b exp 0", busy); end
    endtask

    task automatic test_zero_steps();
        int k;
        int we0, d0;
        we0 = we_cnt;
        d0  = done_cnt;
        @(negedge Clk);
        start     = 1'b1;
        num_steps = 16'd0;
        k = 0;
        while (k < 4) begin
            @(negedge Clk);
            start = 1'b0;
            k++;
            if (done === 1'b1) break;
        end
        checks++; if (done !== 1'b1 || k > 2) begin errors++; $display("FAIL zero_done_latency got done=%b after %0d cycles exp done=1 within 2", done, k); end
        checks++; if (step_count !== 16'd0) begin errors++; $display("FAIL zero_step got %0d exp 0", step_count); end
        repeat (4) @(negedge Clk);
        checks++; if (we_cnt != we0) begin errors++; $display("FAIL zero_we got %0d writes exp 0", we_cnt - we0); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL zero_done_count got %0d exp 1", done_cnt - d0); end
        checks++; if (result_bank !== 1'b0) begin errors++; $display("FAIL zero_bank got %b exp 0", result_bank); end
    endtask

    task automatic test_identity();
        int cyc, d0, bad;
        bit to;
        pe_fifo_mode = 1'b0;
        pe_add       = 1'b0;
        preload();
        d0 = done_cnt;
        start_run(16'd1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL id_busy got %b exp 1", busy); end
        wait_done(5000, cyc, to);
        checks++; if (to) begin errors++; $display("FAIL id_timeout got %0d cycles exp done", cyc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL id_busy_at_done got %b exp 0", busy); end
        checks++; if (result_bank !== 1'b1) begin errors++; $display("FAIL id_bank got %b exp 1", result_bank); end
        checks++; if (step_count !== 16'd1) begin errors++; $display("FAIL id_step got %0d exp 1", step_count); end
        @(negedge Clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL id_done_width got %b exp 0", done); end
        bad = 0;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (mem_b[i] !== exp_vec(i, 0)) begin
                errors++;
                if (bad < 4) $display("FAIL id_b[%0d] got %h exp %h", i, mem_b[i], exp_vec(i, 0));
                bad++;
            end
        end
        repeat (3) @(negedge Clk);
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL id_done_count got %0d exp 1", done_cnt - d0); end
    endtask

    task automatic test_three_steps();
        int cyc, bad;
        bit to;
        pe_fifo_mode = 1'b0;
        pe_add       = 1'b1;
        preload();
        start_run(16'd3);
        wait_done(10000, cyc, to);
        checks++; if (to) begin errors++; $display("FAIL s3_timeout got %0d cycles exp done", cyc); end
        checks++; if (step_count !== 16'd3) begin errors++; $display("FAIL s3_step got %0d exp 3", step_count); end
        checks++; if (result_bank !== 1'b1) begin errors++; $display("FAIL s3_bank got %b exp 1", result_bank); end
        bad = 0;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (mem_b[i] !== exp_vec(i, 3)) begin
                errors++;
                if (bad < 4) $display("FAIL s3_b[%0d] got %h exp %h", i, mem_b[i], exp_vec(i, 3));
                bad++;
            end
        end
        checks++; if (mem_a[17] !== exp_vec(17, 2)) begin errors++; $display("FAIL s3_a17 got %h exp %h", mem_a[17], exp_vec(17, 2)); end
    endtask

    task automatic test_stalls();
        int cyc, bad, s0, v0, d0;
        bit to;
        pe_fifo_mode = 1'b1;
        pe_add       = 1'b1;
        preload();
        s0 = stall_seen;
        v0 = stall_viol;
        d0 = done_cnt;
        start_run(16'd2);
        wait_done(30000, cyc, to);
        checks++; if (to) begin errors++; $display("FAIL st_timeout got %0d cycles exp done", cyc); end
        checks++; if (step_count !== 16'd2) begin errors++; $display("FAIL st_step got %0d exp 2", step_count); end
        checks++; if (result_bank !== 1'b0) begin errors++; $display("FAIL st_bank got %b exp 0", result_bank); end
        checks++; if (cnt !== 3'd0) begin errors++; $display("FAIL st_fifo_left got %0d exp 0", cnt); end
        bad = 0;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (mem_a[i] !== exp_vec(i, 2) || mem_b[i] !== exp_vec(i, 1)) begin
                errors++;
                if (bad < 4) $display("FAIL st_cell[%0d] got a=%h b=%h exp a=%h", i, mem_a[i], mem_b[i], exp_vec(i, 2));
                bad++;
            end
        end
        repeat (3) @(negedge Clk);
        checks++; if (stall_seen == s0) begin errors++; $display("FAIL st_no_stalls got %0d exp >0", stall_seen - s0); end
        checks++; if (stall_viol != v0) begin errors++; $display("FAIL st_unstable got %0d exp 0", stall_viol - v0); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL st_done_count got %0d exp 1", done_cnt - d0); end
        pe_fifo_mode = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int cyc, bad;
        bit to;
        pe_fifo_mode = 1'b0;
        pe_add       = 1'b1;
        preload();
        start_run(16'd3);
        cyc = 0;
        while (!(step_count == 16'd1 && pe_in_valid && pe_in_address == 8'd100) && cyc < 5000) begin
            @(negedge Clk);
            cyc++;
        end
        checks++; if (cyc >= 5000) begin errors++; $display("FAIL rm_reach got %0d cycles exp cell 100 of step 2", cyc); end
        Reset = 1'b1;
        @(negedge Clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy got %b exp 0", busy); end
        checks++; if ({a_WE, b_WE} !== 2'b00) begin errors++; $display("FAIL rm_we got %b exp 00", {a_WE, b_WE}); end
        checks++; if (pe_in_valid !== 1'b0) begin errors++; $display("FAIL rm_pe_valid got %b exp 0", pe_in_valid); end
        checks++; if (mem_a[100] !== exp_vec(100, 0)) begin errors++; $display("FAIL rm_a100 got %h exp %h", mem_a[100], exp_vec(100, 0)); end
        checks++; if (mem_a[99] !== exp_vec(99, 2)) begin errors++; $display("FAIL rm_a99 got %h exp %h", mem_a[99], exp_vec(99, 2)); end
        checks++; if (mem_b[100] !== exp_vec(100, 1)) begin errors++; $display("FAIL rm_b100 got %h exp %h", mem_b[100], exp_vec(100, 1)); end
        Reset  = 1'b0;
        pe_add = 1'b0;
        start_run(16'd1);
        wait_done(5000, cyc, to);
        checks++; if (to) begin errors++; $display("FAIL rm_rerun_timeout got %0d cycles exp done", cyc); end
        checks++; if (result_bank !== 1'b1 || step_count !== 16'd1) begin errors++; $display("FAIL rm_rerun_state got bank=%b step=%0d exp bank=1 step=1", result_bank, step_count); end
        bad = 0;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (mem_b[i] !== exp_vec(i, (i < 100) ? 2 : 0)) begin
                errors++;
                if (bad < 4) $display("FAIL rm_b[%0d] got %h exp %h", i, mem_b[i], exp_vec(i, (i < 100) ? 2 : 0));
                bad++;
            end
        end
    endtask

    task automatic test_back_to_back_start();
        int cyc, d0, bad;
        bit to;
        pe_fifo_mode = 1'b0;
        pe_add       = 1'b1;
        preload();
        d0 = done_cnt;
        start_run(16'd2);
        repeat (10) @(negedge Clk);
        start     = 1'b1;
        num_steps = 16'd5;
        @(negedge Clk);
        start     = 1'b0;
        num_steps = 16'd0;
        wait_done(10000, cyc, to);
        checks++; if (to) begin errors++; $display("FAIL bb_timeout got %0d cycles exp done", cyc); end
        checks++; if (step_count !== 16'd2) begin errors++; $display("FAIL bb_step got %0d exp 2", step_count); end
        checks++; if (result_bank !== 1'b0) begin errors++; $display("FAIL bb_bank got %b exp 0", result_bank); end
        repeat (10) @(negedge Clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bb_rerun got busy=%b exp 0", busy); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL bb_done_count got %0d exp 1", done_cnt - d0); end
        bad = 0;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (mem_a[i] !== exp_vec(i, 2)) begin
                errors++;
                if (bad < 4) $display("FAIL bb_a[%0d] got %h exp %h", i, mem_a[i], exp_vec(i, 2));
                bad++;
            end
        end
    endtask

    initial begin
        Reset        = 1'b1;
        start        = 1'b0;
        num_steps    = '0;
        preload_en   = 1'b0;
        pe_fifo_mode = 1'b0;
        pe_add       = 1'b0;
        test_reset();
        test_zero_steps();
        test_identity();
        test_three_steps();
        test_stalls();
        test_reset_mid_run();
        test_back_to_back_start();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
